// File: rtl/uart_rx_cfg.sv
// Parametrised UART receiver: input synchroniser, start-glitch rejection, framing check.
// Optional parity checking is compiled in when UART_RX_PARITY_EN is defined.
//
// state  | meaning
// IDLE   | waiting for a 1->0 edge on the synchronised line
// START  | waiting for start-bit centre to confirm (else false start)
// DATA   | sampling NB_DATA bits at their centres, LSB first
// PARITY | sampling the parity bit (UART_RX_PARITY_EN only)
// STOP   | sampling NB_STOP stop bits; done pulse at the last centre
module uart_rx_cfg #(
    parameter int NB_DATA     = 8,
    parameter int OVERSAMPLE  = 16,
    parameter int NB_STOP     = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_s_tick,
    input  logic               i_rx,
    input  logic               i_parity_odd,
    output logic [NB_DATA-1:0] o_rx_data,
    output logic               o_rx_done_tick,
    output logic               o_frame_err,
    output logic               o_parity_err,
    output logic               o_busy
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(NB_DATA + 1);
    localparam logic [TW-1:0] TICK_HALF = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(NB_DATA - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(NB_STOP - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    state_t                 state_q;
    logic [SYNC_STAGES-1:0] sync_q;
    logic [TW-1:0]          tick_q;
    logic [BW-1:0]          bit_q;
    logic [NB_DATA-1:0]     shift_q;
    logic                   frame_acc_q;
    logic                   seen_high_q;
    logic                   rx_s;

    // Sync chain resets to all ones so a reset never looks like a start edge.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], i_rx};
        end
    end

    assign rx_s   = sync_q[SYNC_STAGES-1];
    assign o_busy = (state_q != ST_IDLE);

`ifdef UART_RX_PARITY_EN
    logic par_acc_q;
`else
    logic unused_parity_odd;
    assign unused_parity_odd = i_parity_odd;
    assign o_parity_err      = 1'b0;
`endif

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q        <= ST_IDLE;
            tick_q         <= '0;
            bit_q          <= '0;
            shift_q        <= '0;
            frame_acc_q    <= 1'b0;
            seen_high_q    <= 1'b0;
            o_rx_data      <= '0;
            o_rx_done_tick <= 1'b0;
            o_frame_err    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_acc_q      <= 1'b0;
            o_parity_err   <= 1'b0;
`endif
        end else begin
            o_rx_done_tick <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    tick_q <= '0;
                    if (rx_s) begin
                        seen_high_q <= 1'b1;
                    end else if (seen_high_q) begin
                        state_q <= ST_START;
                    end
                end
                ST_START: begin
                    if (i_s_tick) begin
                        if (tick_q == TICK_HALF) begin
                            tick_q <= '0;
                            if (!rx_s) begin
                                state_q     <= ST_DATA;
                                bit_q       <= '0;
                                shift_q     <= '0;
                                frame_acc_q <= 1'b0;
                            end else begin
                                state_q <= ST_IDLE;
                            end
                        end else begin
                            tick_q <= tick_q + TW'(1);
                        end
                    end
                end
                ST_DATA: begin
                    if (i_s_tick) begin
                        if (tick_q == TICK_LAST) begin
                            tick_q  <= '0;
                            shift_q <= {rx_s, shift_q[NB_DATA-1:1]};
                            if (bit_q == DATA_LAST) begin
                                bit_q <= '0;
`ifdef UART_RX_PARITY_EN
                                state_q <= ST_PARITY;
`else
                                state_q <= ST_STOP;
`endif
                            end else begin
                                bit_q <= bit_q + BW'(1);
                            end
                        end else begin
                            tick_q <= tick_q + TW'(1);
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (i_s_tick) begin
                        if (tick_q == TICK_LAST) begin
                            tick_q    <= '0;
                            par_acc_q <= ^shift_q ^ rx_s ^ i_parity_odd;
                            state_q   <= ST_STOP;
                        end else begin
                            tick_q <= tick_q + TW'(1);
                        end
                    end
                end
`endif
                ST_STOP: begin
                    if (i_s_tick) begin
                        if (tick_q == TICK_LAST) begin
                            tick_q <= '0;
                            if (bit_q == STOP_LAST) begin
                                // Leave at the last centre so a back-to-back start is still caught.
                                state_q        <= ST_IDLE;
                                o_rx_done_tick <= 1'b1;
                                o_rx_data      <= shift_q;
                                o_frame_err    <= frame_acc_q | ~rx_s;
                                seen_high_q    <= rx_s & ~frame_acc_q;
`ifdef UART_RX_PARITY_EN
                                o_parity_err   <= par_acc_q;
`endif
                            end else begin
                                bit_q       <= bit_q + BW'(1);
                                frame_acc_q <= frame_acc_q | ~rx_s;
                            end
                        end else begin
                            tick_q <= tick_q + TW'(1);
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: an 8N1 instance and a 7-bit/2-stop instance sharing one tick.
// Parity frames and expectations follow UART_RX_PARITY_EN when it is defined.
module tb_uart_rx_cfg;

    localparam int BIT_CLK = 64;   // 16 ticks x 4 clk

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0;
    logic       rx1 = 1'b1;
    logic       rx2 = 1'b1;
    logic       podd = 1'b0;
    logic [7:0] data1;
    logic [6:0] data2;
    logic       done1, fe1, pe1, busy1;
    logic       done2, fe2, pe2, busy2;

    int checks = 0;
    int errors = 0;
    int tdiv   = 0;
    logic prev_done1 = 1'b0, prev_done2 = 1'b0, long_pulse = 1'b0;

    typedef struct {
        logic [8:0] d;
        logic       fe;
        logic       pe;
    } cap_t;
    cap_t q1[$];
    cap_t q2[$];

    uart_rx_cfg #(.NB_DATA(8), .OVERSAMPLE(16), .NB_STOP(1), .SYNC_STAGES(2)) dut1 (
        .i_clk(clk), .i_reset(rst), .i_s_tick(tick), .i_rx(rx1), .i_parity_odd(podd),
        .o_rx_data(data1), .o_rx_done_tick(done1), .o_frame_err(fe1),
        .o_parity_err(pe1), .o_busy(busy1));

    uart_rx_cfg #(.NB_DATA(7), .OVERSAMPLE(16), .NB_STOP(2), .SYNC_STAGES(2)) dut2 (
        .i_clk(clk), .i_reset(rst), .i_s_tick(tick), .i_rx(rx2), .i_parity_odd(podd),
        .o_rx_data(data2), .o_rx_done_tick(done2), .o_frame_err(fe2),
        .o_parity_err(pe2), .o_busy(busy2));

    always #5 clk = ~clk;

    always @(posedge clk) begin
        tdiv <= (tdiv == 3) ? 0 : tdiv + 1;
        tick <= (tdiv == 3);
    end

    always @(negedge clk) begin
        if (done1) q1.push_back('{d: {1'b0, data1}, fe: fe1, pe: pe1});
        if (done2) q2.push_back('{d: {2'b0, data2}, fe: fe2, pe: pe2});
        if ((done1 && prev_done1) || (done2 && prev_done2)) long_pulse = 1'b1;
        prev_done1 = done1;
        prev_done2 = done2;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic exp_perr(input logic [8:0] d, input logic pbit, input logic odd);
`ifdef UART_RX_PARITY_EN
        return ((($countones(d) + int'(pbit)) % 2) == 1) != odd;
`else
        return 1'b0;
`endif
    endfunction

    task automatic drive_bit(input int which, input logic v);
        if (which == 1) rx1 = v;
        else rx2 = v;
        repeat (BIT_CLK) @(negedge clk);
    endtask

    task automatic send(input int which, input logic [8:0] d, input int nb, input logic pbit,
                        input logic s1, input logic s2, input int nstop);
        drive_bit(which, 1'b0);
        for (int i = 0; i < nb; i++) drive_bit(which, d[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit(which, pbit);
`endif
        drive_bit(which, s1);
        if (nstop == 2) drive_bit(which, s2);
        if (which == 1) rx1 = 1'b1;
        else rx2 = 1'b1;
    endtask

    task automatic expect_frame(input int which, input string tag, input logic [8:0] d,
                                input logic fe, input logic pe);
        cap_t c;
        for (int i = 0; i < 400 && ((which == 1) ? q1.size() : q2.size()) == 0; i++)
            @(negedge clk);
        if (((which == 1) ? q1.size() : q2.size()) == 0) begin
            check({tag, "_done_timeout"}, 32'd0, 32'd1);
            return;
        end
        c = (which == 1) ? q1.pop_front() : q2.pop_front();
        check({tag, "_data"}, 32'(c.d), 32'(d));
        check({tag, "_frame_err"}, 32'(c.fe), 32'(fe));
        check({tag, "_parity_err"}, 32'(c.pe), 32'(pe));
        check({tag, "_busy"}, 32'((which == 1) ? busy1 : busy2), 32'd0);
    endtask

    task automatic idle(input int bits);
        repeat (bits * BIT_CLK) @(negedge clk);
    endtask

    initial begin
        logic [8:0] d;
        logic       pb, s1, s2;

        repeat (5) @(negedge clk);
        check("reset_data1", 32'(data1), 32'd0);
        check("reset_busy1", 32'(busy1), 32'd0);
        check("reset_flags1", {29'd0, done1, fe1, pe1}, 32'd0);
        check("reset_data2", 32'(data2), 32'd0);
        rst = 1'b0;
        idle(1);

        d = 9'h0A5; pb = ^d[7:0];
        send(1, d, 8, pb, 1'b1, 1'b1, 1);
        expect_frame(1, "a5", d, 1'b0, exp_perr(d, pb, podd));
        idle(1);

        rx1 = 1'b0;
        repeat (20) @(negedge clk);
        rx1 = 1'b1;
        idle(2);
        check("glitch_no_done", 32'(q1.size()), 32'd0);
        check("glitch_busy", 32'(busy1), 32'd0);
        check("glitch_data_held", 32'(data1), 32'h0A5);

        d = 9'h03C; pb = ^d[7:0];
        send(1, d, 8, pb, 1'b0, 1'b1, 1);
        expect_frame(1, "3c_stop0", d, 1'b1, exp_perr(d, pb, podd));
        idle(2);

`ifdef UART_RX_PARITY_EN
        podd = 1'b0;
        send(1, 9'h007, 8, 1'b0, 1'b1, 1'b1, 1);
        expect_frame(1, "par07_p0", 9'h007, 1'b0, 1'b1);
        idle(1);
        send(1, 9'h007, 8, 1'b1, 1'b1, 1'b1, 1);
        expect_frame(1, "par07_p1", 9'h007, 1'b0, 1'b0);
        idle(1);
`endif

        for (int n = 0; n < 8; n++) begin
            d    = 9'($urandom_range(0, 255));
            pb   = 1'($urandom_range(0, 1));
            podd = 1'($urandom_range(0, 1));
            s1   = ($urandom_range(0, 3) != 0);
            send(1, d, 8, pb, s1, 1'b1, 1);
            podd = ~podd;
            expect_frame(1, "rand1", d, ~s1, exp_perr(d, pb, ~podd));
            idle(2);
        end

        podd = 1'b0;
        send(2, 9'h055, 7, ^9'h055, 1'b1, 1'b1, 2);
        send(2, 9'h02A, 7, ^9'h02A, 1'b1, 1'b1, 2);
        expect_frame(2, "b2b_55", 9'h055, 1'b0, 1'b0);
        expect_frame(2, "b2b_2a", 9'h02A, 1'b0, 1'b0);
        idle(1);
        send(2, 9'h02A, 7, ^9'h02A, 1'b1, 1'b0, 2);
        expect_frame(2, "stop2_low", 9'h02A, 1'b1, 1'b0);
        idle(2);

        for (int n = 0; n < 4; n++) begin
            d  = 9'($urandom_range(0, 127));
            pb = 1'($urandom_range(0, 1));
            s1 = ($urandom_range(0, 3) != 0);
            s2 = ($urandom_range(0, 3) != 0);
            send(2, d, 7, pb, s1, s2, 2);
            expect_frame(2, "rand2", d, ~(s1 & s2), exp_perr(d, pb, podd));
            idle(2);
        end

        rx1 = 1'b0;
        repeat (BIT_CLK) @(negedge clk);
        rx1 = 1'b1;
        repeat (4 * BIT_CLK + BIT_CLK / 2) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        idle(6);
        check("rst_no_done", 32'(q1.size()), 32'd0);
        check("rst_data_zero", 32'(data1), 32'd0);
        check("rst_busy", 32'(busy1), 32'd0);

        d = 9'h081; pb = ^d[7:0];
        send(1, d, 8, pb, 1'b1, 1'b1, 1);
        expect_frame(1, "after_rst_81", d, 1'b0, exp_perr(d, pb, podd));
        idle(1);

        check("no_extra_pulses", 32'(q1.size() + q2.size()), 32'd0);
        check("single_cycle_done", 32'(long_pulse), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
